// File: rtl/uart_pkg.sv
// Shared definitions for the RX-side serial blocks.
//
// Contents:
//   rx_state_t  - receiver FSM state encoding (3 bits)
//   PAR_*       - parity mode selectors for the PARITY parameter
//   clog2       - ceiling log2, used to size counters at elaboration time
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Number of bits needed to hold the values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rx_sync.sv
// Multi-flop synchroniser for an asynchronous, idle-high serial line.
// The chain resets to all ones so that reset never looks like a start bit.
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   d    - asynchronous input
//   q    - synchronised output, STAGES clocks behind d
module rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Plain shift chain; only the last stage is used downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/serial_rx_param.sv
// Parametrised UART receiver for the board control link.
// Synchronises rx, takes a 3-sample majority vote around each mid-bit,
// rejects false starts, checks parity/framing, flags breaks and presents
// each word through a valid/ready register with overrun reporting.
//
// Ports:
//   clk         - system clock
//   rst         - asynchronous active-low reset
//   rx          - asynchronous serial line, idle high
//   data        - received word, held while data_valid is high
//   data_valid  - word available
//   data_ready  - consumer accepts the word when data_valid is also high
//   parity_err  - parity mismatch for the held word (0 without parity)
//   frame_err   - a stop bit of the held word was sampled low
//   break_det   - held word was an all-low frame (break)
//   overrun     - one-cycle pulse when a completed frame was dropped
module serial_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 1302,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun
);

    localparam int CTR_W = clog2(CLK_PER_BIT);
    localparam int BIT_W = clog2(DATA_BITS + 1);
    localparam int MID   = CLK_PER_BIT / 2;

    localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(CLK_PER_BIT - 1);
    localparam logic [CTR_W-1:0] CTR_S0   = CTR_W'(MID - 1);
    localparam logic [CTR_W-1:0] CTR_S1   = CTR_W'(MID);
    localparam logic [CTR_W-1:0] CTR_S2   = CTR_W'(MID + 1);
    localparam logic [CTR_W-1:0] CTR_DEC  = CTR_W'(MID + 2);

    generate
        if (CLK_PER_BIT < 8) begin : g_bad_clk_per_bit
            $error("serial_rx_param: CLK_PER_BIT must be >= 8");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("serial_rx_param: DATA_BITS must be 5..9");
        end
        if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
            $error("serial_rx_param: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("serial_rx_param: STOP_BITS must be 1 or 2");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync_stages
            $error("serial_rx_param: SYNC_STAGES must be >= 2");
        end
    endgenerate

    rx_state_t            state_q;
    rx_state_t            state_d;
    logic                 rx_s;
    logic [CTR_W-1:0]     ctr_q;
    logic [BIT_W-1:0]     bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [2:0]           vote_q;
    logic                 par_bit_q;
    logic                 par_err_q;
    logic                 stop_err_q;

    logic decide;
    logic maj;
    logic last_data;
    logic last_stop;
    logic par_expected;
    logic frame_err_now;
    logic break_now;
    logic frame_done;
    logic load_out;
    logic drop_out;

    rx_sync #(
        .STAGES (SYNC_STAGES)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Decision strobes and per-frame results. A decision happens two cycles
    // after the mid-bit sample so that all three votes are registered.
    always_comb begin
        decide        = (state_q == START || state_q == DATA ||
                         state_q == uart_pkg::PARITY || state_q == STOP) &&
                        (ctr_q == CTR_DEC);
        maj           = (vote_q[0] & vote_q[1]) | (vote_q[0] & vote_q[2]) |
                        (vote_q[1] & vote_q[2]);
        last_data     = (bit_q == BIT_W'(DATA_BITS - 1));
        last_stop     = (bit_q == BIT_W'(STOP_BITS - 1));
        par_expected  = (PARITY == PAR_ODD) ? ~^shift_q : ^shift_q;
        frame_err_now = stop_err_q | ~maj;
        // par_bit_q stays 0 without parity, so it drops out of the break test.
        break_now     = frame_err_now && (shift_q == '0) && !par_bit_q;
        frame_done    = (state_q == STOP) && decide && last_stop;
        load_out      = frame_done && (!data_valid || data_ready);
        drop_out      = frame_done && data_valid && !data_ready;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (decide) begin
                    state_d = maj ? IDLE : DATA;
                end
            end
            DATA: begin
                if (decide && last_data) begin
                    state_d = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                end
            end
            uart_pkg::PARITY: begin
                if (decide) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (frame_done) begin
                    state_d = frame_err_now ? WAIT_HIGH : IDLE;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bit timing and frame datapath. The counter starts at 0 on the first
    // START cycle and then wraps freely, so every decision lands exactly
    // CLK_PER_BIT cycles after the previous one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctr_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            vote_q     <= '1;
            par_bit_q  <= 1'b0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
        end else begin
            if (state_q == IDLE || state_d == IDLE || state_d == WAIT_HIGH) begin
                ctr_q <= '0;
            end else if (ctr_q == CTR_LAST) begin
                ctr_q <= '0;
            end else begin
                ctr_q <= ctr_q + 1'b1;
            end

            if (ctr_q == CTR_S0) begin
                vote_q[0] <= rx_s;
            end
            if (ctr_q == CTR_S1) begin
                vote_q[1] <= rx_s;
            end
            if (ctr_q == CTR_S2) begin
                vote_q[2] <= rx_s;
            end

            case (state_q)
                IDLE: begin
                    bit_q      <= '0;
                    par_bit_q  <= 1'b0;
                    par_err_q  <= 1'b0;
                    stop_err_q <= 1'b0;
                end
                DATA: begin
                    if (decide) begin
                        shift_q <= {maj, shift_q[DATA_BITS-1:1]};
                        bit_q   <= last_data ? '0 : bit_q + 1'b1;
                    end
                end
                uart_pkg::PARITY: begin
                    if (decide) begin
                        par_bit_q <= maj;
                        par_err_q <= (maj != par_expected);
                    end
                end
                STOP: begin
                    if (decide) begin
                        bit_q      <= bit_q + 1'b1;
                        stop_err_q <= frame_err_now;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output register. A new frame may load in the same cycle the old word
    // is accepted; otherwise a frame arriving on a full register is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data       <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (load_out) begin
                data       <= shift_q;
                parity_err <= par_err_q;
                frame_err  <= frame_err_now;
                break_det  <= break_now;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
            overrun <= drop_out;
        end
    end

endmodule

// File: tb/tb_serial_rx_param.sv
// Directed self-checking bench for serial_rx_param at CLK_PER_BIT = 16.
// Instance dut is 8N1, instance dut_p is 8E1. Frames are driven bit by bit,
// a negedge monitor records every accepted word, and the directed steps
// compare the recorded words and live outputs against hand-computed values.
module tb_serial_rx_param;
    import uart_pkg::*;

    localparam int CPB = 16;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       bk;
        int         cyc;
    } word_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rx_p;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ready;
    logic       parity_err;
    logic       frame_err;
    logic       break_det;
    logic       overrun;
    logic [7:0] data_p;
    logic       data_valid_p;
    logic       data_ready_p;
    logic       parity_err_p;
    logic       frame_err_p;
    logic       break_det_p;
    logic       overrun_p;

    int    n_assert = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    start_cyc;
    int    dv_cycles = 0;
    int    ovr_cnt   = 0;
    int    ovr_base;
    word_t q_main[$];
    word_t q_par[$];

    serial_rx_param #(
        .CLK_PER_BIT (CPB),
        .DATA_BITS   (8),
        .PARITY      (0),
        .STOP_BITS   (1),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .break_det  (break_det),
        .overrun    (overrun)
    );

    serial_rx_param #(
        .CLK_PER_BIT (CPB),
        .DATA_BITS   (8),
        .PARITY      (2),
        .STOP_BITS   (1),
        .SYNC_STAGES (2)
    ) dut_p (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx_p),
        .data       (data_p),
        .data_valid (data_valid_p),
        .data_ready (data_ready_p),
        .parity_err (parity_err_p),
        .frame_err  (frame_err_p),
        .break_det  (break_det_p),
        .overrun    (overrun_p)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every handshake and count valid / overrun cycles.
    always @(negedge clk) begin
        if (data_valid && data_ready) begin
            q_main.push_back('{data: data, pe: parity_err, fe: frame_err, bk: break_det, cyc: cyc});
        end
        if (data_valid_p && data_ready_p) begin
            q_par.push_back('{data: data_p, pe: parity_err_p, fe: frame_err_p, bk: break_det_p, cyc: cyc});
        end
        if (data_valid) dv_cycles <= dv_cycles + 1;
        if (overrun) ovr_cnt <= ovr_cnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic set_line(input bit sel, input logic v);
        if (sel) rx_p = v;
        else     rx   = v;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bit time; entered and left at posedge+1. An optional one-cycle low
    // spike lands on the middle vote sample of the bit.
    task automatic drive_bit(input bit sel, input logic v, input bit spike);
        for (int c = 0; c < CPB; c++) begin
            set_line(sel, (spike && c == 9) ? 1'b0 : v);
            @(posedge clk);
            #1;
        end
    endtask

    // Start bit, 8 data bits LSB first, optional parity bit, one stop bit.
    task automatic applyStimulus(input bit sel, input logic [7:0] value, input bit with_par,
                                 input logic par_val, input logic stop_val, input int spike_bit);
        @(posedge clk);
        #1;
        start_cyc = cyc;
        drive_bit(sel, 1'b0, spike_bit == 0);
        for (int b = 0; b < 8; b++) begin
            drive_bit(sel, value[b], spike_bit == b + 1);
        end
        if (with_par) drive_bit(sel, par_val, 1'b0);
        drive_bit(sel, stop_val, 1'b0);
    endtask

    task automatic checkWord(input string tag, input bit sel, input logic [7:0] exp_data,
                             input logic exp_pe, input logic exp_fe, input logic exp_bk);
        word_t w;
        w = '{data: 8'hxx, pe: 1'bx, fe: 1'bx, bk: 1'bx, cyc: -1};
        if (!sel && q_main.size() > 0) w = q_main.pop_front();
        if (sel && q_par.size() > 0)   w = q_par.pop_front();
        checkOutput({tag, "_data"}, 32'(w.data), 32'(exp_data));
        checkOutput({tag, "_perr"}, 32'(w.pe), 32'(exp_pe));
        checkOutput({tag, "_ferr"}, 32'(w.fe), 32'(exp_fe));
        checkOutput({tag, "_brk"},  32'(w.bk), 32'(exp_bk));
    endtask

    initial begin
        word_t w;
        rx           = 1'b1;
        rx_p         = 1'b1;
        data_ready   = 1'b1;
        data_ready_p = 1'b1;
        rst          = 1'b1;
        #2 rst = 1'b0;
        idle(3);

        $display("[TB] reset state");
        checkOutput("rst_data",  32'(data), 32'h0);
        checkOutput("rst_valid", 32'(data_valid), 32'h0);
        checkOutput("rst_flags", 32'({parity_err, frame_err, break_det, overrun}), 32'h0);
        checkOutput("rst_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b1;
        idle(4);

        // 8N1 0xA5: valid rises 158 cycles after the start edge is driven
        // (2 sync + 1 detect + 9 bit times + mid-bit 8 + 3 vote/load cycles).
        $display("[TB] 8N1 frame 0xA5");
        dv_cycles = 0;
        applyStimulus(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, -1);
        idle(10);
        checkOutput("a5_count", 32'(q_main.size()), 32'd1);
        checkOutput("a5_valid_cycles", 32'(dv_cycles), 32'd1);
        if (q_main.size() > 0) checkOutput("a5_latency", 32'(q_main[0].cyc - start_cyc), 32'd158);
        checkWord("a5", 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);

        // Even parity: ^0x03 = 0, so parity bit 1 is wrong and 0 is right.
        $display("[TB] even parity frames");
        applyStimulus(1'b1, 8'h03, 1'b1, 1'b1, 1'b1, -1);
        idle(10);
        if (q_par.size() > 0) checkOutput("par_latency", 32'(q_par[0].cyc - start_cyc), 32'd174);
        checkWord("par_bad", 1'b1, 8'h03, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h03, 1'b1, 1'b0, 1'b1, -1);
        idle(10);
        checkWord("par_good", 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);

        $display("[TB] framing error then recovery");
        applyStimulus(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, -1);
        idle(40);
        checkWord("ferr", 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0);
        checkOutput("ferr_wait_high", 32'(dut.state_q), 32'(WAIT_HIGH));
        rx = 1'b1;
        idle(5);
        checkOutput("ferr_back_idle", 32'(dut.state_q), 32'(IDLE));
        idle(16);
        applyStimulus(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, -1);
        idle(10);
        checkWord("after_ferr", 1'b0, 8'h11, 1'b0, 1'b0, 1'b0);

        $display("[TB] break of 20 bit times");
        rx = 1'b0;
        idle(20 * CPB);
        checkOutput("brk_count_low", 32'(q_main.size()), 32'd1);
        rx = 1'b1;
        idle(40);
        checkOutput("brk_count_high", 32'(q_main.size()), 32'd1);
        checkWord("brk", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        $display("[TB] start glitch and mid-bit spike");
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(30);
        checkOutput("glitch_count", 32'(q_main.size()), 32'd0);
        checkOutput("glitch_state", 32'(dut.state_q), 32'(IDLE));
        applyStimulus(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 4);
        idle(10);
        checkWord("spike", 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);

        $display("[TB] overrun");
        data_ready = 1'b0;
        ovr_base   = ovr_cnt;
        applyStimulus(1'b0, 8'h12, 1'b0, 1'b0, 1'b1, -1);
        idle(4);
        applyStimulus(1'b0, 8'h34, 1'b0, 1'b0, 1'b1, -1);
        idle(10);
        checkOutput("ovr_data_held", 32'(data), 32'h12);
        checkOutput("ovr_valid", 32'(data_valid), 32'h1);
        checkOutput("ovr_pulses", 32'(ovr_cnt - ovr_base), 32'd1);
        checkOutput("ovr_no_accept", 32'(q_main.size()), 32'd0);
        data_ready = 1'b1;
        idle(2);
        checkOutput("ovr_valid_cleared", 32'(data_valid), 32'h0);
        checkWord("ovr_first", 1'b0, 8'h12, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h56, 1'b0, 1'b0, 1'b1, -1);
        idle(10);
        checkWord("ovr_third", 1'b0, 8'h56, 1'b0, 1'b0, 1'b0);

        $display("[TB] reset mid-frame");
        drive_bit(1'b0, 1'b0, 1'b0);
        drive_bit(1'b0, 1'b1, 1'b0);
        drive_bit(1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        checkOutput("mid_rst_data", 32'(data), 32'h0);
        checkOutput("mid_rst_valid", 32'(data_valid), 32'h0);
        checkOutput("mid_rst_flags", 32'({parity_err, frame_err, break_det, overrun}), 32'h0);
        checkOutput("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
        rx = 1'b1;
        idle(2);
        rst = 1'b1;
        idle(300);
        checkOutput("mid_rst_no_word", 32'(q_main.size()), 32'd0);
        checkOutput("mid_rst_valid_after", 32'(data_valid), 32'h0);

        w = '{data: 8'h00, pe: 1'b0, fe: 1'b0, bk: 1'b0, cyc: 0};
        if (q_par.size() > 0) w = q_par.pop_front();
        checkOutput("par_no_extra", 32'(w.cyc), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
